// File: rtl/fft_frame_loader.sv
// Serial-to-parallel frame loader feeding the 8-point FFT, with result-latency tracking.
// Build option: define FRAME_OVERLAP_EN for a 4-sample hop (50 % overlap); default hop is 8.
module fft_frame_loader #(
  parameter int FFT_LATENCY = 3,
  parameter bit SIGNED_IN   = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic [11:0] x_0,
  output logic [11:0] x_1,
  output logic [11:0] x_2,
  output logic [11:0] x_3,
  output logic [11:0] x_4,
  output logic [11:0] x_5,
  output logic [11:0] x_6,
  output logic [11:0] x_7,
  output logic        frame_valid,
  output logic        result_valid,
  output logic [7:0]  frame_cnt,
  output logic        filling
);

`ifdef FRAME_OVERLAP_EN
  localparam logic [2:0] HOP_LAST = 3'd3;
`else
  localparam logic [2:0] HOP_LAST = 3'd7;
`endif

  typedef enum logic {FILL, RUN} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             cnt_q, cnt_d;
  logic                   emit;
  logic [11:0]            sr_q [8];
  logic [11:0]            x_q [8];
  logic [11:0]            sample_conv;
  logic                   frame_valid_q;
  logic [7:0]             frame_cnt_q;
  logic [FFT_LATENCY-1:0] pipe_q, pipe_d;

  // Offset-binary ADC codes become two's complement by flipping the MSB.
  assign sample_conv = SIGNED_IN ? sample_in : {~sample_in[11], sample_in[10:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (clr) begin
      state_d = FILL;
      cnt_d   = '0;
    end else if (sample_valid) begin
      case (state_q)
        FILL: begin
          if (cnt_q == 3'd7) begin
            state_d = RUN;
            cnt_d   = '0;
            emit    = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        RUN: begin
          if (cnt_q == HOP_LAST) begin
            cnt_d = '0;
            emit  = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        default: begin
          state_d = FILL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    filling = (state_q == FILL);
  end

  // Shift frame_valid into the latency pipe; a single-stage pipe just loses the shifted bit.
  always_comb begin
    pipe_d    = pipe_q << 1;
    pipe_d[0] = frame_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        sr_q[i] <= '0;
        x_q[i]  <= '0;
      end
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
      pipe_q        <= '0;
    end else begin
      frame_valid_q <= emit;
      pipe_q        <= clr ? '0 : pipe_d;
      if (clr) begin
        for (int i = 0; i < 8; i++) sr_q[i] <= '0;
      end else if (sample_valid) begin
        for (int i = 0; i < 7; i++) sr_q[i] <= sr_q[i+1];
        sr_q[7] <= sample_conv;
      end
      // The frame is taken from the post-shift view so the completing sample lands in x_7.
      if (emit) begin
        for (int i = 0; i < 7; i++) x_q[i] <= sr_q[i+1];
        x_q[7]      <= sample_conv;
        frame_cnt_q <= frame_cnt_q + 8'd1;
      end
    end
  end

  assign x_0          = x_q[0];
  assign x_1          = x_q[1];
  assign x_2          = x_q[2];
  assign x_3          = x_q[3];
  assign x_4          = x_q[4];
  assign x_5          = x_q[5];
  assign x_6          = x_q[6];
  assign x_7          = x_q[7];
  assign frame_valid  = frame_valid_q;
  assign frame_cnt    = frame_cnt_q;
  assign result_valid = pipe_q[FFT_LATENCY-1];

endmodule

// File: tb/tb_fft_frame_loader.sv
// Self-checking bench for fft_frame_loader: a sample-history model checked every cycle plus
// directed literal checks. Honours FRAME_OVERLAP_EN the same way the design does.
module tb_fft_frame_loader;

  localparam int FFT_LATENCY = 3;
`ifdef FRAME_OVERLAP_EN
  localparam int HOP = 4;
`else
  localparam int HOP = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic [11:0] x_0, x_1, x_2, x_3, x_4, x_5, x_6, x_7;
  logic        frame_valid, result_valid, filling;
  logic [7:0]  frame_cnt;
  logic [11:0] xOut [8];

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  fft_frame_loader #(.FFT_LATENCY(FFT_LATENCY), .SIGNED_IN(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .sample_in(sample_in), .sample_valid(sample_valid),
    .x_0(x_0), .x_1(x_1), .x_2(x_2), .x_3(x_3), .x_4(x_4), .x_5(x_5), .x_6(x_6), .x_7(x_7),
    .frame_valid(frame_valid), .result_valid(result_valid), .frame_cnt(frame_cnt),
    .filling(filling)
  );

  assign xOut[0] = x_0;
  assign xOut[1] = x_1;
  assign xOut[2] = x_2;
  assign xOut[3] = x_3;
  assign xOut[4] = x_4;
  assign xOut[5] = x_5;
  assign xOut[6] = x_6;
  assign xOut[7] = x_7;

  // Model: keep the last eight converted samples and the count since reset/clr; a frame is due
  // on the 8th capture and every HOP captures after that. Pending results count down to zero.
  logic [11:0] hist [$];
  int          pending [$];
  int          nSince;
  logic [11:0] expX [8];
  logic        expFv, expRv, expFill;
  logic [7:0]  expCnt;
  logic        newRv;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      pending.delete();
      nSince = 0;
      for (int i = 0; i < 8; i++) expX[i] = 12'h000;
      expFv  = 1'b0;
      expRv  = 1'b0;
      expCnt = 8'd0;
    end else begin
      newRv = 1'b0;
      if (clr) begin
        pending.delete();
      end else begin
        foreach (pending[i]) pending[i] = pending[i] - 1;
        if (expFv) pending.push_back(FFT_LATENCY - 1);
        if (pending.size() > 0 && pending[0] == 0) begin
          newRv = 1'b1;
          void'(pending.pop_front());
        end
      end
      expFv = 1'b0;
      if (clr) begin
        hist.delete();
        nSince = 0;
      end else if (sample_valid) begin
        hist.push_back(sample_in ^ 12'h800);
        if (hist.size() > 8) void'(hist.pop_front());
        nSince++;
        if (nSince >= 8 && (nSince - 8) % HOP == 0) begin
          expFv = 1'b1;
          for (int i = 0; i < 8; i++) expX[i] = hist[i];
          expCnt = expCnt + 8'd1;
        end
      end
      expRv = newRv;
    end
    expFill = (nSince < 8);
  end

  task automatic checkOutput(input string name, input logic [11:0] actual,
                             input logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%03h, expected 0x%03h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int k = 0; k < 8; k++) checkOutput($sformatf("model x_%0d", k), xOut[k], expX[k]);
      checkOutput("model frame_valid", {11'd0, frame_valid}, {11'd0, expFv});
      checkOutput("model result_valid", {11'd0, result_valid}, {11'd0, expRv});
      checkOutput("model frame_cnt", {4'd0, frame_cnt}, {4'd0, expCnt});
      checkOutput("model filling", {11'd0, filling}, {11'd0, expFill});
    end
  end

  // Called at a negedge; holds the strobe across exactly one rising edge.
  task automatic applyStimulus(input logic [11:0] v);
    sample_in    = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clrPulse(input logic withSample);
    clr          = 1'b1;
    sample_valid = withSample;
    sample_in    = 12'h123;
    @(negedge clk);
    clr          = 1'b0;
    sample_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  lat;
    bit  wrapped;
    rst_n        = 1'b1;
    clr          = 1'b0;
    sample_in    = 12'h000;
    sample_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1 checkEn = 1'b1;
    idle(2);

    $display("[TB] reset values");
    checkOutput("reset x_0", x_0, 12'h000);
    checkOutput("reset x_7", x_7, 12'h000);
    checkOutput("reset frame_valid", {11'd0, frame_valid}, 12'h000);
    checkOutput("reset result_valid", {11'd0, result_valid}, 12'h000);
    checkOutput("reset frame_cnt", {4'd0, frame_cnt}, 12'h000);
    checkOutput("reset filling", {11'd0, filling}, 12'h001);
    rst_n = 1'b1;
    idle(1);

    $display("[TB] first frame 0x800..0x807");
    for (int i = 0; i < 8; i++) applyStimulus(12'h800 + 12'(i));
    checkOutput("first frame_valid", {11'd0, frame_valid}, 12'h001);
    checkOutput("first x_0", x_0, 12'h000);
    checkOutput("first x_3", x_3, 12'h003);
    checkOutput("first x_7", x_7, 12'h007);
    checkOutput("first frame_cnt", {4'd0, frame_cnt}, 12'h001);
    checkOutput("first filling", {11'd0, filling}, 12'h000);
    checkOutput("model pin x_7", expX[7], 12'h007);
    lat = 0;
    while (!result_valid && lat < 20) begin
      idle(1);
      lat++;
    end
    checkOutput("result latency", 12'(lat), 12'(FFT_LATENCY));
    idle(2);

    $display("[TB] offset-binary extremes");
    applyStimulus(12'h000);
    applyStimulus(12'hFFF);
    for (int i = 0; i < 6; i++) applyStimulus(12'h805);
    checkOutput("extreme x_0", x_0, 12'h800);
    checkOutput("extreme x_1", x_1, 12'h7FF);
`ifdef FRAME_OVERLAP_EN
    checkOutput("extreme frame_cnt", {4'd0, frame_cnt}, 12'h003);
`else
    checkOutput("extreme frame_cnt", {4'd0, frame_cnt}, 12'h002);
`endif
    idle(3);

    $display("[TB] stream 1..24 with gaps");
    clrPulse(1'b0);
    for (int i = 1; i <= 24; i++) begin
      applyStimulus(12'h800 + 12'(i));
      if (i == 16) begin
        checkOutput("stream16 x_0", x_0, 12'h009);
        checkOutput("stream16 x_7", x_7, 12'h010);
      end
      idle(i % 3);
    end
    checkOutput("stream x_0", x_0, 12'h011);
    checkOutput("stream x_7", x_7, 12'h018);
    idle(4);

    $display("[TB] clr with simultaneous sample");
    clrPulse(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(12'h8AA);
    clrPulse(1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(12'h900);
    checkOutput("clr held x_7", x_7, 12'h018);
    checkOutput("clr no frame", {11'd0, frame_valid}, 12'h000);
    applyStimulus(12'h900);
    checkOutput("clr frame_valid", {11'd0, frame_valid}, 12'h001);
    checkOutput("clr x_0", x_0, 12'h100);
    checkOutput("clr x_7", x_7, 12'h100);
    idle(4);

    $display("[TB] frame counter wrap");
    wrapped = 1'b0;
    for (int i = 0; i < 4000 && !wrapped; i++) begin
      applyStimulus(12'(i));
      if (frame_valid && expCnt == 8'd0) wrapped = 1'b1;
    end
    checkOutput("wrap reached", {11'd0, wrapped}, 12'h001);
    checkOutput("wrap frame_cnt", {4'd0, frame_cnt}, 12'h000);
    idle(2);

    $display("[TB] async reset mid-frame");
    clrPulse(1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(12'h8C0);
    for (int i = 0; i < 3; i++) applyStimulus(12'h8C1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async x_0", x_0, 12'h000);
    checkOutput("async x_7", x_7, 12'h000);
    checkOutput("async frame_cnt", {4'd0, frame_cnt}, 12'h000);
    checkOutput("async frame_valid", {11'd0, frame_valid}, 12'h000);
    checkOutput("async result_valid", {11'd0, result_valid}, 12'h000);
    checkOutput("async filling", {11'd0, filling}, 12'h001);
    idle(2);
    rst_n = 1'b1;
    idle(1);
    for (int i = 0; i < 8; i++) applyStimulus(12'h80A);
    checkOutput("post-reset x_0", x_0, 12'h00A);
    checkOutput("post-reset frame_cnt", {4'd0, frame_cnt}, 12'h001);
    idle(FFT_LATENCY + 2);

    checkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
